// File: rtl/spi_host_mock_pkg.sv
// spi_host_mock_pkg: shared state encoding and constants for the UART-emulated SPI host.
package spi_host_mock_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] TIMEOUT_PAD = 32'hFFFF_FFFF;
endpackage

// File: rtl/spi_host_mock_uart.sv
// spi_host_mock_uart: 8N1 UART core with AXI-stream byte ports; one bit lasts prescale*8 cycles.
module spi_host_mock_uart (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prescale,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        rxd,
  output logic        txd
);
  logic [18:0] bit_cycles, half_cycles, tx_cnt, rx_cnt;
  logic [8:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [3:0]  tx_bits, rx_bits;
  logic        tx_busy, rx_busy, rx_meta, rx_s;
  assign bit_cycles    = {prescale, 3'b000} - 19'd1;
  assign half_cycles   = {1'b0, prescale, 2'b00} - 19'd1;
  assign s_axis_tready = !tx_busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      txd     <= 1'b1;
      tx_sh   <= '0;
      tx_bits <= '0;
      tx_cnt  <= '0;
    end else if (!tx_busy) begin
      if (s_axis_tvalid) begin
        tx_busy <= 1'b1;
        txd     <= 1'b0;
        tx_sh   <= {1'b1, s_axis_tdata};
        tx_bits <= 4'd9;
        tx_cnt  <= bit_cycles;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 19'd1;
    end else if (tx_bits != '0) begin
      txd     <= tx_sh[0];
      tx_sh   <= {1'b0, tx_sh[8:1]};
      tx_bits <= tx_bits - 4'd1;
      tx_cnt  <= bit_cycles;
    end else begin
      tx_busy <= 1'b0;
    end
  end
  // rx_bits: 9 = start-bit check, 8..1 = data bits, 0 = stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_busy       <= 1'b0;
      rx_sh         <= '0;
      rx_bits       <= '0;
      rx_cnt        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_bits <= 4'd9;
          rx_cnt  <= half_cycles;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 19'd1;
      end else if (rx_bits == 4'd9) begin
        rx_busy <= !rx_s;
        rx_bits <= 4'd8;
        rx_cnt  <= bit_cycles;
      end else if (rx_bits != '0) begin
        rx_sh   <= {rx_s, rx_sh[7:1]};
        rx_bits <= rx_bits - 4'd1;
        rx_cnt  <= bit_cycles;
      end else begin
        rx_busy <= 1'b0;
        if (rx_s) begin
          m_axis_tdata  <= rx_sh;
          m_axis_tvalid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/spi_host_mock.sv
// spi_host_mock: sends 32-bit requests as four UART bytes LSB first and assembles the
// four-byte reply into a response word, padding with all-ones on inter-byte timeout.
module spi_host_mock
  import spi_host_mock_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk100mhz,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic [31:0] req_data,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_timeout,
  output logic        busy
);
  localparam logic [15:0] PRESCALE = 16'(CLK_HZ / (BAUD * 8));
  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
  state_t        state, state_next;
  logic [31:0]   sh, tmp;
  logic [1:0]    cnt;
  logic [TW-1:0] tmr;
  logic [7:0]    rx_data;
  logic          tx_valid, tx_ready, tx_hs, rx_valid, rx_hs;
  logic          accept, last_tx, last_rx, expire, consume;
  spi_host_mock_uart u_uart (
    .clk           (clk100mhz),
    .rst           (~reset),
    .prescale      (PRESCALE),
    .s_axis_tdata  (sh[7:0]),
    .s_axis_tvalid (tx_valid),
    .s_axis_tready (tx_ready),
    .m_axis_tdata  (rx_data),
    .m_axis_tvalid (rx_valid),
    .m_axis_tready (1'b1),
    .rxd           (uart_rxd),
    .txd           (uart_txd)
  );
  assign req_ready = reset && state == S_IDLE;
  assign busy      = state != S_IDLE;
  assign tx_valid  = state == S_SEND;
  assign tx_hs     = tx_valid && tx_ready;
  assign rx_hs     = rx_valid && state == S_RECV;
  always_comb begin
    accept     = req_valid && req_ready;
    last_tx    = tx_hs && cnt == LAST;
    last_rx    = rx_hs && cnt == LAST;
    expire     = state == S_RECV && !rx_valid && tmr == TW'(TIMEOUT_CYCLES - 1);
    consume    = state == S_DONE && rsp_ready;
    state_next = accept ? S_SEND :
                 last_tx ? S_RECV :
                 (last_rx || expire) ? S_DONE :
                 consume ? S_IDLE : state;
  end
  always_ff @(posedge clk100mhz) state <= !reset ? S_IDLE : state_next;
  // Stray RX bytes outside RECV are taken by the core but never reach tmp
  always_ff @(posedge clk100mhz) begin
    if (!reset) begin
      sh          <= '0;
      tmp         <= '0;
      cnt         <= '0;
      tmr         <= '0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        sh  <= req_data;
        cnt <= '0;
      end
      if (tx_hs) begin
        sh  <= {8'h00, sh[31:8]};
        cnt <= cnt + 2'd1;
        tmr <= '0;
      end
      if (state == S_RECV) tmr <= rx_valid ? '0 : tmr + TW'(1);
      if (rx_hs) begin
        tmp <= {rx_data, tmp[31:8]};
        cnt <= cnt + 2'd1;
      end
      if (last_rx) begin
        rsp_data    <= {rx_data, tmp[31:8]};
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b0;
      end
      if (expire) begin
        rsp_data    <= TIMEOUT_PAD;
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b1;
      end
      if (consume) begin
        rsp_valid   <= 1'b0;
        rsp_timeout <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_host_mock.sv
// tb_spi_host_mock: directed exchanges against a bench-side UART slave and response model.
module tb_spi_host_mock;
  localparam int BIT = 16;
  localparam int T   = 2000;
  logic        clk, reset, uart_rxd, uart_txd, req_valid, req_ready;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] req_data, rsp_data;
  int          n_tests = 0, n_fail = 0;
  logic        in_x = 1'b0, exp_to = 1'b0, last_to;
  logic [31:0] exp_data = '0, last_rsp;
  logic [7:0]  txq[$], reply_q[$];

  spi_host_mock #(.CLK_HZ(1600000), .BAUD(100000), .TIMEOUT_CYCLES(T)) dut (
    .clk100mhz(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Exchange-level model: busy/req_ready follow the bench's view of an open exchange
  always @(negedge clk) if (reset) begin
    chk("busy", busy, in_x);
    chk("req_ready", req_ready, !in_x);
    if (!in_x) chk("rsp_valid_idle", rsp_valid, 0);
    if (rsp_valid) begin
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_timeout", rsp_timeout, exp_to);
    end
  end

  // Line decoder for the request side, sampled mid-bit
  initial forever begin
    @(negedge clk);
    if (reset && uart_txd == 1'b0) begin
      logic [7:0] b;
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (BIT) @(negedge clk);
      if (uart_txd) txq.push_back(b);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic accept(input logic [31:0] req);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    chk("req_ready_wait", req_ready, 1);
    req_data  = req;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    in_x = 1'b1;
  endtask

  task automatic exchange(input logic [31:0] req, input logic stray_done);
    int w;
    logic [31:0] e;
    e = '0;
    foreach (reply_q[i]) e |= 32'(reply_q[i]) << (8 * i);
    exp_to   = reply_q.size() < 4;
    exp_data = exp_to ? 32'hFFFF_FFFF : e;
    txq.delete();
    accept(req);
    w = 0;
    while (txq.size() < 4 && w < 2000) begin @(negedge clk); w++; end
    chk("tx_byte_count", 32'(txq.size()), 4);
    for (int i = 0; i < 4 && i < txq.size(); i++) chk("tx_byte", txq[i], req[8*i +: 8]);
    foreach (reply_q[i]) send_byte(reply_q[i]);
    w = 0;
    while (!rsp_valid && w < T + 400) begin @(negedge clk); w++; end
    chk("rsp_valid_seen", rsp_valid, 1);
    if (exp_to) chk("timeout_latency", 32'(w >= T - 20 && w <= T + 20), 1);
    else chk("rsp_latency", 32'(w <= 2), 1);
    last_rsp = rsp_data;
    last_to  = rsp_timeout;
    if (stray_done) begin
      send_byte(8'h55);
      repeat (20) @(negedge clk);
      chk("rsp_hold_data", rsp_data, last_rsp);
      chk("rsp_hold_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    in_x = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txd", uart_txd, 1);
  endtask

  initial begin
    reset = 1'b0; uart_rxd = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_data = '0;
    repeat (4) @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready, 1);

    reply_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exchange(32'h12345678, 1'b0);
    chk("pin_full", last_rsp, 32'hD4C3B2A1);
    chk("pin_full_to", last_to, 0);

    reply_q = '{8'hA1, 8'hB2};
    exchange(32'h0BADF00D, 1'b0);
    chk("pin_timeout", last_rsp, 32'hFFFF_FFFF);
    chk("pin_timeout_to", last_to, 1);

    reply_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exchange(32'h00000001, 1'b1);
    chk("pin_after_timeout", last_rsp, 32'h44332211);

    send_byte(8'h99);
    repeat (20) @(negedge clk);
    reply_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    exchange(32'h55AA55AA, 1'b0);
    chk("pin_stray", last_rsp, 32'h04030201);

    exp_to = 1'b0;
    txq.delete();
    accept(32'h11223344);
    begin
      int w;
      w = 0;
      while (txq.size() < 1 && w < 1000) begin @(negedge clk); w++; end
      chk("tx_first_before_reset", 32'(txq.size()), 1);
    end
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    in_x = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("req_ready_after_midreset", req_ready, 1);
    repeat (200) @(negedge clk);
    reply_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    exchange(32'hCAFEBABE, 1'b0);
    chk("pin_after_reset", last_rsp, 32'h8D7C6B5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
